arb_pattern_gen_v2: RTL

//  Single-clock successor to the arbitrary pattern generator. It replays a NUM_SIG-wide pattern from on-chip

---
 rtl/arb_pattern_gen_v2.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/arb_pattern_gen_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arb_pattern_gen_v2                                            |
// | Brief    : Single-clock pattern replay / capture engine with loops,      |
// |            abort and pass status. Optional APG_EXT_TRIG_EN adds ext_trig.|
// | Revision : 2.0                                                           |
// +--------------------------------------------------------------------------+
module arb_pattern_gen_v2 #(
    parameter int NUM_SIG  = 32,
    parameter int NUM_SAMP = 1024,
    parameter int DIV_W    = 16
) (
    input  logic               axi_clk,
    input  logic               axi_resetn,
    input  logic               run,
    input  logic               abort,
    input  logic [31:0]        n_samples,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic [15:0]        loop_count,
    input  logic [7:0]         control,
    input  logic [NUM_SIG-1:0] write_channel,
    input  logic               write_channel_wrStrobe,
    output logic [NUM_SIG-1:0] read_channel,
    input  logic               read_channel_rdStrobe,
    output logic [NUM_SIG-1:0] output_signals,
    input  logic [NUM_SIG-1:0] input_signals,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pass_count
`ifdef APG_EXT_TRIG_EN
    ,
    input  logic               ext_trig
`endif
);

    localparam int c_AW = (NUM_SAMP > 1) ? $clog2(NUM_SAMP) : 1;
    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(NUM_SAMP - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW-1:0]    r_idx;
    logic [c_AW-1:0]    r_n_last;
    logic [c_AW-1:0]    w_n_last;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [15:0]        r_loop;
    logic [NUM_SIG-1:0] r_pat_q;
    logic               r_pat_vld;

    logic [NUM_SIG-1:0] r_pat [NUM_SAMP];
    logic [NUM_SIG-1:0] r_cap [NUM_SAMP];

    logic w_idle;
    logic w_in_run;
    logic w_start;
    logic w_tick;
    logic w_pass_end;
    logic w_more;
    logic w_rd_fire;
    logic w_pat_we;
    logic w_cap_rd;
    logic w_cap_we;
    logic w_trig_rise;
    logic w_trig_wait;
    logic w_unused_ctrl;

`ifdef APG_EXT_TRIG_EN
    logic [2:0] r_trig_sync;

    // Two synchroniser stages plus one delay stage for rising-edge detection
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_trig_sync <= 3'b000;
        end else begin
            r_trig_sync <= {r_trig_sync[1:0], ext_trig};
        end
    end

    assign w_trig_rise   = r_trig_sync[1] & ~r_trig_sync[2];
    assign w_trig_wait   = control[1];
    assign w_unused_ctrl = ^control[7:3];
`else
    assign w_trig_rise   = 1'b0;
    assign w_trig_wait   = 1'b0;
    assign w_unused_ctrl = ^{control[7:3], control[1]};
`endif

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_in_run   = (r_state == c_ST_RUN);
    assign w_start    = w_idle && run && !abort;
    assign w_tick     = w_in_run && (r_div_cnt == r_div);
    assign w_pass_end = w_tick && (r_idx == r_n_last);
    assign w_more     = control[0] &&
                        ((r_loop == 16'd0) || (({1'b0, pass_count} + 17'd1) < {1'b0, r_loop}));
    assign w_rd_fire  = w_in_run && (r_div_cnt == '0);
    assign w_pat_we   = w_idle && write_channel_wrStrobe && !control[2];
    assign w_cap_rd   = w_idle && read_channel_rdStrobe && !control[2];
    assign w_cap_we   = w_tick && !abort;

    // Clamp the requested sample count into 1..NUM_SAMP, stored as last index
    always_comb begin
        if (n_samples == 32'd0) begin
            w_n_last = '0;
        end else if (n_samples >= 32'(NUM_SAMP)) begin
            w_n_last = c_LAST_ADDR;
        end else begin
            w_n_last = c_AW'(n_samples - 32'd1);
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_next_state = w_trig_wait ? c_ST_WAIT : c_ST_RUN;
                end
            end
            c_ST_WAIT: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_trig_rise) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_pass_end && !w_more) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_ST_WAIT) || (r_state == c_ST_RUN);
    end

    always_ff @(posedge axi_clk) begin
        if (w_pat_we) begin
            r_pat[r_wr_ptr] <= write_channel;
        end
        if (w_rd_fire) begin
            r_pat_q <= r_pat[r_idx];
        end
    end

    always_ff @(posedge axi_clk) begin
        if (w_cap_we) begin
            r_cap[r_idx] <= input_signals;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_idx          <= '0;
            r_n_last       <= '0;
            r_div          <= '0;
            r_div_cnt      <= '0;
            r_loop         <= '0;
            r_pat_vld      <= 1'b0;
            read_channel   <= '0;
            output_signals <= '0;
            done           <= 1'b0;
            pass_count     <= '0;
        end else begin
            done      <= 1'b0;
            r_pat_vld <= w_rd_fire && !abort;
            // Second pipeline stage keeps draining after the last tick returns to IDLE
            if (r_pat_vld && !abort) begin
                output_signals <= r_pat_q;
            end

            if (w_idle && control[2]) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end
            if (w_pat_we) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_cap_rd) begin
                read_channel <= r_cap[r_rd_ptr];
                r_rd_ptr     <= (r_rd_ptr == c_LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
            end

            if (w_start) begin
                r_rd_ptr   <= '0;
                pass_count <= '0;
                r_div      <= clk_div;
                r_n_last   <= w_n_last;
                r_loop     <= loop_count;
                r_idx      <= '0;
                r_div_cnt  <= '0;
            end

            if (w_in_run && !abort) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    if (w_pass_end) begin
                        if (pass_count != 16'hFFFF) begin
                            pass_count <= pass_count + 16'd1;
                        end
                        r_idx <= '0;
                        if (!w_more) begin
                            done <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
